// File: rtl/dcache_responder_pkg.sv
// Shared cache geometry defaults, line type and controller state encoding.
// Pure definitions: no logic, no latency, no flow control.
package definitions;

  localparam int DCACHE_NUM_LINES  = 16;
  localparam int DCACHE_LINE_BYTES = 16;
  localparam int DCACHE_ADDR_W     = 32;

  typedef logic [8*DCACHE_LINE_BYTES-1:0] dcache_line_t;

  typedef enum logic [1:0] {
    DCACHE_IDLE,
    DCACHE_WRITEBACK,
    DCACHE_FILL
  } dcache_state_t;

endpackage

// File: rtl/dcache_responder_if.sv
// Requester handshake plus line-wide memory port of the data-cache responder.
// Slave is the cache; master is the pipeline/memory side driving it.
interface dcache_responder_if
  import definitions::*;
#(
  parameter int ADDR_W     = DCACHE_ADDR_W,
  parameter int LINE_BYTES = DCACHE_LINE_BYTES
);
  logic                    valid_i;
  logic [ADDR_W-1:0]       addr_i;
  logic                    we_i;
  logic [3:0]              be_i;
  logic [31:0]             wdata_i;
  logic [31:0]             rdata_o;
  logic                    ready_o;
  logic                    miss_o;
  logic                    mem_req_o;
  logic                    mem_we_o;
  logic [ADDR_W-1:0]       mem_addr_o;
  logic [8*LINE_BYTES-1:0] mem_wdata_o;
  logic                    mem_ready_i;
  logic [8*LINE_BYTES-1:0] mem_rdata_i;

  modport slave (
    input  valid_i, addr_i, we_i, be_i, wdata_i, mem_ready_i, mem_rdata_i,
    output rdata_o, ready_o, miss_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output valid_i, addr_i, we_i, be_i, wdata_i, mem_ready_i, mem_rdata_i,
    input  rdata_o, ready_o, miss_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dcache_responder_cache_line_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one byte-enabled write port.
// Writes land at the clock edge; only valid and dirty bits are cleared by reset.
module cache_line_array
  import definitions::*;
#(
  parameter int NUM_LINES  = DCACHE_NUM_LINES,
  parameter int LINE_BYTES = DCACHE_LINE_BYTES,
  parameter int TAG_W      = 24,
  localparam int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [IDX_W-1:0]        rd_idx_i,
  output logic                    rd_valid_o,
  output logic                    rd_dirty_o,
  output logic [TAG_W-1:0]        rd_tag_o,
  output logic [8*LINE_BYTES-1:0] rd_line_o,
  input  logic [IDX_W-1:0]        wr_idx_i,
  input  logic [LINE_BYTES-1:0]   wr_be_i,
  input  logic [8*LINE_BYTES-1:0] wr_line_i,
  input  logic                    wr_tag_en_i,
  input  logic [TAG_W-1:0]        wr_tag_i,
  input  logic                    set_valid_i,
  input  logic                    set_dirty_i,
  input  logic                    clr_dirty_i
);
  logic [8*LINE_BYTES-1:0] data_q [NUM_LINES];
  logic [TAG_W-1:0]        tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0]    valid_q;
  logic [NUM_LINES-1:0]    dirty_q;

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (wr_be_i[b]) data_q[wr_idx_i][8*b +: 8] <= wr_line_i[8*b +: 8];
    end
    if (wr_tag_en_i) tag_q[wr_idx_i] <= wr_tag_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (set_valid_i) valid_q[wr_idx_i] <= 1'b1;
      if (set_dirty_i)      dirty_q[wr_idx_i] <= 1'b1;
      else if (clr_dirty_i) dirty_q[wr_idx_i] <= 1'b0;
    end
  end
endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back cache responder: hits answer combinationally in the request cycle;
// misses hold miss_o while a registered memory port runs writeback (if dirty) then fill.
module dcache_responder
  import definitions::*;
#(
  parameter int NUM_LINES  = DCACHE_NUM_LINES,
  parameter int LINE_BYTES = DCACHE_LINE_BYTES,
  parameter int ADDR_W     = DCACHE_ADDR_W
) (
  input logic              clk_i,
  input logic              reset_i,
  dcache_responder_if.slave bus
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WORDS  = LINE_BYTES / 4;
  localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LINE_W = 8 * LINE_BYTES;

  dcache_state_t     state_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  tag_q;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] word_sel;
  logic              hit, ready, miss;

  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic [WORDS-1:0][31:0] rd_words;

  logic [IDX_W-1:0]      wr_idx;
  logic [LINE_BYTES-1:0] wr_be;
  logic [LINE_W-1:0]     wr_line;
  logic                  wr_tag_en, set_valid, set_dirty, clr_dirty;

  assign req_idx  = bus.addr_i[OFF_W +: IDX_W];
  assign req_tag  = bus.addr_i[ADDR_W-1 -: TAG_W];
  assign word_sel = WSEL_W'(bus.addr_i[OFF_W-1:0] >> 2);

  cache_line_array #(
    .NUM_LINES  (NUM_LINES),
    .LINE_BYTES (LINE_BYTES),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .rd_idx_i    (req_idx),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_line_o   (rd_line),
    .wr_idx_i    (wr_idx),
    .wr_be_i     (wr_be),
    .wr_line_i   (wr_line),
    .wr_tag_en_i (wr_tag_en),
    .wr_tag_i    (tag_q),
    .set_valid_i (set_valid),
    .set_dirty_i (set_dirty),
    .clr_dirty_i (clr_dirty)
  );

  // Outputs are forced low while reset is held so a stale valid bit cannot answer.
  assign hit      = rd_valid && (rd_tag == req_tag);
  assign ready    = bus.valid_i && !reset_i && (state_q == DCACHE_IDLE) && hit;
  assign miss     = bus.valid_i && !reset_i && ((state_q != DCACHE_IDLE) || !hit);
  assign rd_words = rd_line;

  assign bus.ready_o     = ready;
  assign bus.miss_o      = miss;
  assign bus.rdata_o     = rd_words[word_sel];
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;

  always_comb begin
    wr_idx    = idx_q;
    wr_be     = '0;
    wr_line   = {WORDS{bus.wdata_i}};
    wr_tag_en = 1'b0;
    set_valid = 1'b0;
    set_dirty = 1'b0;
    clr_dirty = 1'b0;
    if (!reset_i) begin
      case (state_q)
        DCACHE_IDLE: begin
          wr_idx = req_idx;
          if (ready && bus.we_i) begin
            for (int w = 0; w < WORDS; w++) begin
              if (word_sel == WSEL_W'(w)) wr_be[4*w +: 4] = bus.be_i;
            end
            set_dirty = 1'b1;
          end
        end
        DCACHE_WRITEBACK: clr_dirty = bus.mem_ready_i;
        DCACHE_FILL: begin
          if (bus.mem_ready_i) begin
            wr_be     = '1;
            wr_line   = bus.mem_rdata_i;
            wr_tag_en = 1'b1;
            set_valid = 1'b1;
            clr_dirty = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= DCACHE_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      idx_q       <= '0;
      tag_q       <= '0;
    end else begin
      case (state_q)
        DCACHE_IDLE: begin
          if (bus.valid_i && !hit) begin
            idx_q     <= req_idx;
            tag_q     <= req_tag;
            mem_req_q <= 1'b1;
            if (rd_valid && rd_dirty) begin
              state_q     <= DCACHE_WRITEBACK;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {rd_tag, req_idx, {OFF_W{1'b0}}};
              mem_wdata_q <= rd_line;
            end else begin
              state_q    <= DCACHE_FILL;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {req_tag, req_idx, {OFF_W{1'b0}}};
            end
          end
        end
        DCACHE_WRITEBACK: begin
          if (bus.mem_ready_i) begin
            state_q    <= DCACHE_FILL;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {tag_q, idx_q, {OFF_W{1'b0}}};
          end
        end
        DCACHE_FILL: begin
          if (bus.mem_ready_i) begin
            state_q   <= DCACHE_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: state_q <= DCACHE_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench: cache/memory model with a per-cycle compare, plus literal per-test expectations.
module tb_dcache_responder;
  import definitions::*;

  localparam int NL = 16;
  localparam int LB = 16;
  localparam int AW = 32;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dcache_responder_if #(.ADDR_W(AW), .LINE_BYTES(LB)) bus ();

  dcache_responder #(.NUM_LINES(NL), .LINE_BYTES(LB), .ADDR_W(AW)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [127:0] mem_lines [int unsigned];
  int           mem_lat = 3;
  int           mem_cnt = 0;
  int           n_wb = 0, n_fill = 0;
  logic [31:0]  last_wb_addr = '0, last_fill_addr = '0;
  logic [127:0] last_wb_data = '0;

  logic         m_valid [NL];
  logic         m_dirty [NL];
  logic [23:0]  m_tag   [NL];
  logic [127:0] m_data  [NL];
  txn_t         txn_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] pat_line(input logic [31:0] a);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[32*w +: 32] = 32'hA000_0000 | (a + 32'(4*w));
    return l;
  endfunction

  function automatic logic [127:0] get_line(input logic [31:0] a);
    if (mem_lines.exists(a)) return mem_lines[a];
    return pat_line(a);
  endfunction

  // Memory: pulses mem_ready_i in the mem_lat-th cycle of each request.
  initial begin
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      if (reset || !bus.mem_req_o || bus.mem_ready_i) begin
        bus.mem_ready_i = 1'b0;
        mem_cnt = 0;
      end else begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          bus.mem_ready_i = 1'b1;
          mem_cnt = 0;
          if (bus.mem_we_o) begin
            mem_lines[bus.mem_addr_o] = bus.mem_wdata_o;
            last_wb_addr = bus.mem_addr_o;
            last_wb_data = bus.mem_wdata_o;
            bus.mem_rdata_i = '0;
            n_wb++;
          end else begin
            bus.mem_rdata_i = get_line(bus.mem_addr_o);
            last_fill_addr = bus.mem_addr_o;
            n_fill++;
          end
        end
      end
    end
  end

  // Model: cache contents plus queue of memory transactions still owed by a miss.
  initial begin : monitor
    int           idx, word;
    logic [23:0]  tag;
    logic         hit, busy, exp_rdy, exp_miss;
    txn_t         t;
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end
    forever begin
      @(negedge clk);
      idx      = int'(bus.addr_i[7:4]);
      word     = int'(bus.addr_i[3:2]);
      tag      = bus.addr_i[31:8];
      hit      = m_valid[idx] && (m_tag[idx] == tag);
      busy     = (txn_q.size() != 0);
      exp_rdy  = !reset && bus.valid_i && !busy && hit;
      exp_miss = !reset && bus.valid_i && (busy || !hit);
      check("ready_o", bus.ready_o, exp_rdy);
      check("miss_o", bus.miss_o, exp_miss);
      if (exp_rdy && !bus.we_i) check("rdata_o", bus.rdata_o, m_data[idx][32*word +: 32]);
      check("mem_req_o", bus.mem_req_o, busy);
      if (busy) begin
        check("mem_we_o", bus.mem_we_o, txn_q[0].we);
        check("mem_addr_o", bus.mem_addr_o, txn_q[0].addr);
        if (txn_q[0].we) check("mem_wdata_o", bus.mem_wdata_o, txn_q[0].wdata);
      end
      if (reset) begin
        for (int i = 0; i < NL; i++) begin
          m_valid[i] = 1'b0;
          m_dirty[i] = 1'b0;
        end
        txn_q.delete();
      end else if (busy) begin
        if (bus.mem_ready_i) begin
          t = txn_q.pop_front();
          if (t.we) begin
            m_dirty[int'(t.addr[7:4])] = 1'b0;
          end else begin
            m_data[int'(t.addr[7:4])]  = get_line(t.addr);
            m_tag[int'(t.addr[7:4])]   = t.addr[31:8];
            m_valid[int'(t.addr[7:4])] = 1'b1;
            m_dirty[int'(t.addr[7:4])] = 1'b0;
          end
        end
      end else if (bus.valid_i) begin
        if (hit) begin
          if (bus.we_i) begin
            for (int k = 0; k < 4; k++)
              if (bus.be_i[k]) m_data[idx][32*word + 8*k +: 8] = bus.wdata_i[8*k +: 8];
            m_dirty[idx] = 1'b1;
          end
        end else begin
          if (m_valid[idx] && m_dirty[idx])
            txn_q.push_back('{we: 1'b1, addr: {m_tag[idx], 4'(idx), 4'h0}, wdata: m_data[idx]});
          txn_q.push_back('{we: 1'b0, addr: {tag, 4'(idx), 4'h0}, wdata: '0});
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, output int cyc, output logic [31:0] rd,
                        output logic first_miss);
    @(posedge clk); #1;
    bus.valid_i = 1'b1; bus.addr_i = a; bus.we_i = we; bus.be_i = be; bus.wdata_i = wd;
    cyc = 0; rd = '0; first_miss = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) first_miss = bus.miss_o;
      if (bus.ready_o) begin
        cyc = n;
        rd  = bus.rdata_o;
        break;
      end
    end
    if (cyc == 0) begin
      checks++;
      failures++;
      $display("FAIL req_timeout addr=%0h actual=no ready_o required=ready_o within 60 cycles", a);
    end
    @(posedge clk); #1;
    bus.valid_i = 1'b0; bus.we_i = 1'b0;
  endtask

  task automatic wait_req(input logic want_req, input logic want_we, input string name);
    int ok;
    ok = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.mem_req_o == want_req && (!want_req || bus.mem_we_o == want_we)) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (ok == 0) begin
      failures++;
      $display("FAIL %s actual=timeout required=mem_req_o=%0d", name, want_req);
    end
  endtask

  initial begin
    int          cyc, fills;
    logic [31:0] rd;
    logic        fm, saw_rdy;
    bus.valid_i = 1'b0; bus.addr_i = '0; bus.we_i = 1'b0; bus.be_i = '0; bus.wdata_i = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_ready", bus.ready_o, 1'b0);
    check("reset_miss", bus.miss_o, 1'b0);
    check("reset_mem_req", bus.mem_req_o, 1'b0);

    // 1: cold load, fill only, ready in cycle 5
    do_req(1'b0, 32'h100, 4'h0, 32'h0, cyc, rd, fm);
    check("t1_first_miss", fm, 1'b1);
    check("t1_latency", cyc, 5);
    check("t1_rdata", rd, 32'hA000_0100);
    check("t1_fill_addr", last_fill_addr, 32'h100);
    check("t1_no_wb", n_wb, 0);

    // 2: hit in same cycle, no memory traffic
    fills = n_fill;
    do_req(1'b0, 32'h104, 4'h0, 32'h0, cyc, rd, fm);
    check("t2_latency", cyc, 1);
    check("t2_rdata", rd, 32'hA000_0104);
    check("t2_no_fill", n_fill, fills);

    // 3: store merges under byte enables
    do_req(1'b1, 32'h100, 4'b0011, 32'hDEAD_BEEF, cyc, rd, fm);
    check("t3_store_latency", cyc, 1);
    do_req(1'b1, 32'h10C, 4'b1100, 32'h1234_5678, cyc, rd, fm);
    do_req(1'b0, 32'h100, 4'h0, 32'h0, cyc, rd, fm);
    check("t3_merged_lo", rd, 32'hA000_BEEF);
    do_req(1'b0, 32'h10C, 4'h0, 32'h0, cyc, rd, fm);
    check("t3_merged_hi", rd, 32'h1234_010C);

    // 4: conflict miss on dirty line: writeback then fill
    do_req(1'b0, 32'h200, 4'h0, 32'h0, cyc, rd, fm);
    check("t4_latency", cyc, 9);
    check("t4_rdata", rd, 32'hA000_0200);
    check("t4_wb_addr", last_wb_addr, 32'h100);
    check("t4_wb_word0", last_wb_data[31:0], 32'hA000_BEEF);
    check("t4_wb_word3", last_wb_data[127:96], 32'h1234_010C);
    check("t4_fill_addr", last_fill_addr, 32'h200);

    // 5: reset during fill abandons the miss and invalidates the cache
    mem_lat = 6;
    @(posedge clk); #1;
    bus.valid_i = 1'b1; bus.addr_i = 32'h100; bus.we_i = 1'b0;
    wait_req(1'b1, 1'b0, "t5_wait_fill");
    @(posedge clk); #1;
    reset = 1'b1; bus.valid_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t5_req_after_reset", bus.mem_req_o, 1'b0);
    mem_lat = 3;
    do_req(1'b0, 32'h100, 4'h0, 32'h0, cyc, rd, fm);
    check("t5_miss_again", fm, 1'b1);
    check("t5_latency", cyc, 5);
    check("t5_rdata", rd, 32'hA000_BEEF);

    // 6: requester abandons mid-fill; line still installed
    @(posedge clk); #1;
    bus.valid_i = 1'b1; bus.addr_i = 32'h300; bus.we_i = 1'b0;
    wait_req(1'b1, 1'b0, "t6_wait_fill");
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    saw_rdy = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.ready_o) saw_rdy = 1'b1;
    end
    check("t6_no_ready", saw_rdy, 1'b0);
    check("t6_idle", bus.mem_req_o, 1'b0);
    do_req(1'b0, 32'h308, 4'h0, 32'h0, cyc, rd, fm);
    check("t6_hit_latency", cyc, 1);
    check("t6_rdata", rd, 32'hA000_0308);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
